// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback over a
// shared memory port, handles memory wait states, traps illegal opcodes, counts retirements.
module mips_multicycle_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        pc_write_cond,
  output logic [1:0]  pc_source,
  output logic        i_or_d,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        reg_write,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [2:0]  alu_ctrl,
  output logic [3:0]  state,
  output logic        halted,
  output logic [31:0] instr_count
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    RWB    = 4'd7,
    IMM    = 4'd8,
    IWB    = 4'd9,
    BRANCH = 4'd10,
    JUMP   = 4'd11,
    TRAP   = 4'd15
  } state_t;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_instr_count;
  logic        w_retire;
  logic        w_pc_write;
  logic        w_pc_write_cond;
  logic        w_ir_write;
  logic        w_reg_write;
  logic        w_mem_write;
  logic        w_mem_read;
  logic        w_halted;

  // Any move back into FETCH from another state completes an instruction.
  assign w_retire = (r_state != FETCH) && (w_next == FETCH);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= FETCH;
      r_instr_count <= 32'd0;
    end else begin
      r_state <= w_next;
      if (w_retire) r_instr_count <= r_instr_count + 32'd1;
    end
  end

  always_comb begin
    w_next          = r_state;
    w_pc_write      = 1'b0;
    w_pc_write_cond = 1'b0;
    w_ir_write      = 1'b0;
    w_reg_write     = 1'b0;
    w_mem_write     = 1'b0;
    w_mem_read      = 1'b0;
    w_halted        = 1'b0;
    pc_source       = 2'b00;
    i_or_d          = 1'b0;
    reg_dst         = 1'b0;
    mem_to_reg      = 1'b0;
    alu_src_a       = 1'b0;
    alu_src_b       = 2'b00;
    alu_ctrl        = 3'b000;
    case (r_state)
      FETCH: begin
        w_mem_read = 1'b1;
        alu_src_b  = 2'b01;
        alu_ctrl   = ALU_ADD;
        if (mem_ready) begin
          w_ir_write = 1'b1;
          w_pc_write = 1'b1;
          w_next     = DECODE;
        end
      end
      DECODE: begin
        alu_src_b = 2'b10;
        alu_ctrl  = ALU_ADD;
        case (opcode)
          OP_RTYPE:        w_next = EXEC;
          OP_LW, OP_SW:    w_next = MEMADR;
          OP_BEQ:          w_next = BRANCH;
          OP_ADDI, OP_ORI: w_next = IMM;
          OP_J:            w_next = JUMP;
          default:         w_next = TRAP;
        endcase
      end
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_ctrl  = ALU_ADD;
        w_next    = (opcode == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        w_mem_read = 1'b1;
        i_or_d     = 1'b1;
        if (mem_ready) w_next = MEMWB;
      end
      MEMWB: begin
        w_reg_write = 1'b1;
        mem_to_reg  = 1'b1;
        w_next      = FETCH;
      end
      MEMWR: begin
        w_mem_write = 1'b1;
        i_or_d      = 1'b1;
        if (mem_ready) w_next = FETCH;
      end
      EXEC: begin
        alu_src_a = 1'b1;
        case (funct)
          6'b100010: alu_ctrl = ALU_SUB;
          6'b100100: alu_ctrl = ALU_AND;
          6'b100101: alu_ctrl = ALU_OR;
          6'b101010: alu_ctrl = ALU_SLT;
          default:   alu_ctrl = ALU_ADD;
        endcase
        w_next = RWB;
      end
      RWB: begin
        w_reg_write = 1'b1;
        reg_dst     = 1'b1;
        w_next      = FETCH;
      end
      IMM: begin
        alu_src_a = 1'b1;
        if (opcode == OP_ORI) begin
          alu_src_b = 2'b11;
          alu_ctrl  = ALU_OR;
        end else begin
          alu_src_b = 2'b10;
          alu_ctrl  = ALU_ADD;
        end
        w_next = IWB;
      end
      IWB: begin
        w_reg_write = 1'b1;
        w_next      = FETCH;
      end
      BRANCH: begin
        alu_src_a       = 1'b1;
        alu_ctrl        = ALU_SUB;
        w_pc_write_cond = 1'b1;
        pc_source       = 2'b01;
        w_next          = FETCH;
      end
      JUMP: begin
        w_pc_write = 1'b1;
        pc_source  = 2'b10;
        w_next     = FETCH;
      end
      TRAP: begin
        w_halted = 1'b1;
      end
      default: w_next = TRAP;
    endcase
  end

  // Strobes are gated by reset so nothing is written while reset is held low.
  assign pc_write      = reset & w_pc_write;
  assign pc_write_cond = reset & w_pc_write_cond;
  assign ir_write      = reset & w_ir_write;
  assign reg_write     = reset & w_reg_write;
  assign mem_write     = reset & w_mem_write;
  assign mem_read      = reset & w_mem_read;
  assign halted        = reset & w_halted;
  assign state         = r_state;
  assign instr_count   = r_instr_count;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Randomized bench for mips_multicycle_ctrl: expected state traces are built per instruction
// class with wait cycles inserted, and control outputs come from the per-state output table.
module tb_mips_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [5:0]  opcode = 6'd0;
  logic [5:0]  funct = 6'd0;
  logic        mem_ready = 1'b0;
  logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic        reg_dst, mem_to_reg, reg_write, alu_src_a, halted;
  logic [1:0]  pc_source, alu_src_b;
  logic [2:0]  alu_ctrl;
  logic [3:0]  state;
  logic [31:0] instr_count;

  int          cmpCount = 0;
  int          errCount = 0;
  logic [31:0] refCount = 32'd0;

  int          obsSt[$];
  int          expSt[$];
  logic [17:0] obsCt[$];
  logic [17:0] expCt[$];
  logic [31:0] obsCnt[$];
  logic [31:0] expCnt[$];

  localparam int IRW_BIT = 10;
  localparam int RW_BIT  = 7;

  mips_multicycle_ctrl dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl),
    .state(state), .halted(halted), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [17:0] dutCtrl();
    return {pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write, ir_write,
            reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_ctrl, halted};
  endfunction

  // Output table per state, written straight from the per-state output description.
  function automatic logic [17:0] expCtrlFor(int st, logic [5:0] op, logic [5:0] fn, logic mr);
    logic pw = 0, pwc = 0, iod = 0, mrd = 0, mwr = 0, irw = 0, rdst = 0, m2r = 0, rw = 0;
    logic sa = 0, hlt = 0;
    logic [1:0] psrc = 0, sb = 0;
    logic [2:0] alu = 0;
    case (st)
      0: begin mrd = 1; sb = 2'b01; alu = 3'b010; if (mr) begin irw = 1; pw = 1; end end
      1: begin sb = 2'b10; alu = 3'b010; end
      2: begin sa = 1; sb = 2'b10; alu = 3'b010; end
      3: begin mrd = 1; iod = 1; end
      4: begin rw = 1; m2r = 1; end
      5: begin mwr = 1; iod = 1; end
      6: begin
        sa = 1;
        case (fn)
          6'h22:   alu = 3'b110;
          6'h24:   alu = 3'b000;
          6'h25:   alu = 3'b001;
          6'h2A:   alu = 3'b111;
          default: alu = 3'b010;
        endcase
      end
      7: begin rw = 1; rdst = 1; end
      8: begin sa = 1; if (op == 6'h0D) begin sb = 2'b11; alu = 3'b001; end
                       else begin sb = 2'b10; alu = 3'b010; end end
      9: rw = 1;
      10: begin sa = 1; alu = 3'b110; pwc = 1; psrc = 2'b01; end
      11: begin pw = 1; psrc = 2'b10; end
      15: hlt = 1;
      default: ;
    endcase
    return {pw, pwc, psrc, iod, mrd, mwr, irw, rdst, m2r, rw, sa, sb, alu, hlt};
  endfunction

  function automatic bit isLegal(logic [5:0] op);
    return op inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h0D, 6'h02};
  endfunction

  task automatic clear_trace();
    obsSt.delete(); expSt.delete(); obsCt.delete(); expCt.delete();
    obsCnt.delete(); expCnt.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    mem_ready = 1'b0;
    refCount = 32'd0;
  endtask

  // Drives one instruction from a FETCH-aligned negedge and records observed vs expected.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int fw, input int mw);
    int   seq[$];
    logic mrq[$];
    for (int i = 0; i < fw; i++) begin seq.push_back(0); mrq.push_back(1'b0); end
    seq.push_back(0); mrq.push_back(1'b1);
    seq.push_back(1); mrq.push_back(1'($urandom_range(0, 1)));
    case (op)
      6'h00: begin
        seq.push_back(6); mrq.push_back(1'($urandom_range(0, 1)));
        seq.push_back(7); mrq.push_back(1'($urandom_range(0, 1)));
      end
      6'h23: begin
        seq.push_back(2); mrq.push_back(1'($urandom_range(0, 1)));
        for (int i = 0; i < mw; i++) begin seq.push_back(3); mrq.push_back(1'b0); end
        seq.push_back(3); mrq.push_back(1'b1);
        seq.push_back(4); mrq.push_back(1'($urandom_range(0, 1)));
      end
      6'h2B: begin
        seq.push_back(2); mrq.push_back(1'($urandom_range(0, 1)));
        for (int i = 0; i < mw; i++) begin seq.push_back(5); mrq.push_back(1'b0); end
        seq.push_back(5); mrq.push_back(1'b1);
      end
      6'h04: begin seq.push_back(10); mrq.push_back(1'($urandom_range(0, 1))); end
      6'h08, 6'h0D: begin
        seq.push_back(8); mrq.push_back(1'($urandom_range(0, 1)));
        seq.push_back(9); mrq.push_back(1'($urandom_range(0, 1)));
      end
      6'h02: begin seq.push_back(11); mrq.push_back(1'($urandom_range(0, 1))); end
      default: begin seq.push_back(15); mrq.push_back(1'($urandom_range(0, 1))); end
    endcase
    foreach (seq[i]) begin
      @(negedge clk);
      opcode    = (seq[i] == 0) ? 6'($urandom) : op;
      funct     = (seq[i] == 0) ? 6'($urandom) : fn;
      mem_ready = mrq[i];
      #1;
      if (i == 0) begin obsCnt.push_back(instr_count); expCnt.push_back(refCount); end
      obsSt.push_back(int'(state));
      expSt.push_back(seq[i]);
      obsCt.push_back(dutCtrl());
      expCt.push_back(expCtrlFor(seq[i], op, fn, mrq[i]));
    end
    if (isLegal(op)) refCount = refCount + 32'd1;
  endtask

  task automatic test_reset();
    do_reset();
    run_instr(6'h02, 6'h00, 0, 0);
    clear_trace();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      opcode = 6'h23;
      mem_ready = (i == 0);
      #1;
    end
    cmpCount++;
    if (state !== 4'd3) begin
      errCount++; $display("[TB] FAIL reset_pre_memrd: got %0d expected 3", state);
    end
    reset = 1'b0;
    #1;
    cmpCount++;
    if ({pc_write, pc_write_cond, ir_write, reg_write, mem_write, mem_read, halted} !== 7'd0) begin
      errCount++; $display("[TB] FAIL reset_strobes_async: got %b expected 0",
                           {pc_write, pc_write_cond, ir_write, reg_write, mem_write, mem_read, halted});
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mem_ready = 1'($urandom_range(0, 1));
      #1;
      cmpCount++;
      if (state !== 4'd0 || instr_count !== 32'd0) begin
        errCount++; $display("[TB] FAIL reset_hold: got state %0d count %0d expected 0/0", state, instr_count);
      end
      cmpCount++;
      if ({pc_write, pc_write_cond, ir_write, reg_write, mem_write, mem_read, halted} !== 7'd0) begin
        errCount++; $display("[TB] FAIL reset_strobes: got %b expected 0",
                             {pc_write, pc_write_cond, ir_write, reg_write, mem_write, mem_read, halted});
      end
    end
    reset = 1'b1;
    mem_ready = 1'b0;
    refCount = 32'd0;
    #1;
    cmpCount++;
    if (mem_read !== 1'b1 || i_or_d !== 1'b0 || state !== 4'd0) begin
      errCount++; $display("[TB] FAIL reset_release: got rd %b iod %b st %0d expected 1 0 0", mem_read, i_or_d, state);
    end
  endtask

  task automatic test_sequence();
    logic [31:0] prog [6] = '{32'h20080005, 32'h2009000A, 32'h01095020,
                              32'hAC0A0010, 32'h8C0B0010, 32'h08000005};
    logic [31:0] w;
    do_reset();
    clear_trace();
    for (int k = 0; k < 6; k++) begin
      w = prog[k];
      run_instr(w[31:26], w[5:0], 0, 0);
    end
    foreach (obsSt[i]) begin
      cmpCount++;
      if (obsSt[i] !== expSt[i]) begin
        errCount++; $display("[TB] FAIL seq_state[%0d]: got %0d expected %0d", i, obsSt[i], expSt[i]);
      end
      cmpCount++;
      if (obsCt[i] !== expCt[i]) begin
        errCount++; $display("[TB] FAIL seq_ctrl[%0d]: got %h expected %h", i, obsCt[i], expCt[i]);
      end
    end
    cmpCount++;
    if (obsSt.size() != 24) begin
      errCount++; $display("[TB] FAIL seq_cycles: got %0d expected 24", obsSt.size());
    end
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    cmpCount++;
    if (instr_count !== 32'd6) begin
      errCount++; $display("[TB] FAIL seq_count: got %0d expected 6", instr_count);
    end
    clear_trace();
  endtask

  task automatic test_wait_states();
    int irPulses = 0;
    int rwPulses = 0;
    clear_trace();
    run_instr(6'h23, 6'h00, 2, 3);
    foreach (obsSt[i]) begin
      cmpCount++;
      if (obsSt[i] !== expSt[i] || obsCt[i] !== expCt[i]) begin
        errCount++; $display("[TB] FAIL wait_cycle[%0d]: got st %0d ctrl %h expected st %0d ctrl %h",
                             i, obsSt[i], obsCt[i], expSt[i], expCt[i]);
      end
      if (obsCt[i][IRW_BIT]) irPulses++;
      if (obsCt[i][RW_BIT]) begin
        rwPulses++;
        cmpCount++;
        if (obsSt[i] !== 4) begin
          errCount++; $display("[TB] FAIL wait_rw_state: got %0d expected 4", obsSt[i]);
        end
      end
    end
    cmpCount++;
    if (obsSt.size() != 10) begin
      errCount++; $display("[TB] FAIL wait_cycles: got %0d expected 10", obsSt.size());
    end
    cmpCount++;
    if (irPulses != 1 || rwPulses != 1) begin
      errCount++; $display("[TB] FAIL wait_pulses: got ir %0d rw %0d expected 1 1", irPulses, rwPulses);
    end
    cmpCount++;
    if (obsCnt[0] !== expCnt[0]) begin
      errCount++; $display("[TB] FAIL wait_count: got %0d expected %0d", obsCnt[0], expCnt[0]);
    end
    clear_trace();
  endtask

  task automatic test_alu_decode();
    clear_trace();
    run_instr(6'h00, 6'h22, 0, 0);
    cmpCount++;
    if (obsCt[2][3:1] !== 3'b110) begin
      errCount++; $display("[TB] FAIL alu_sub: got %b expected 110", obsCt[2][3:1]);
    end
    run_instr(6'h00, 6'h2A, 0, 0);
    run_instr(6'h00, 6'h00, 0, 0);
    run_instr(6'h00, 6'h24, 0, 0);
    run_instr(6'h00, 6'h25, 0, 0);
    run_instr(6'h0D, 6'($urandom), 0, 0);
    run_instr(6'h04, 6'($urandom), 1, 0);
    foreach (obsSt[i]) begin
      cmpCount++;
      if (obsSt[i] !== expSt[i] || obsCt[i] !== expCt[i]) begin
        errCount++; $display("[TB] FAIL alu_cycle[%0d]: got st %0d ctrl %h expected st %0d ctrl %h",
                             i, obsSt[i], obsCt[i], expSt[i], expCt[i]);
      end
    end
    foreach (obsCnt[i]) begin
      cmpCount++;
      if (obsCnt[i] !== expCnt[i]) begin
        errCount++; $display("[TB] FAIL alu_count[%0d]: got %0d expected %0d", i, obsCnt[i], expCnt[i]);
      end
    end
    clear_trace();
  endtask

  task automatic test_random();
    logic [5:0] ops [7] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h0D, 6'h02};
    logic [5:0] fns [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h11};
    clear_trace();
    for (int k = 0; k < 40; k++)
      run_instr(ops[$urandom_range(0, 6)], fns[$urandom_range(0, 5)],
                $urandom_range(0, 3), $urandom_range(0, 3));
    foreach (obsSt[i]) begin
      cmpCount++;
      if (obsSt[i] !== expSt[i] || obsCt[i] !== expCt[i]) begin
        errCount++; $display("[TB] FAIL rand_cycle[%0d]: got st %0d ctrl %h expected st %0d ctrl %h",
                             i, obsSt[i], obsCt[i], expSt[i], expCt[i]);
      end
    end
    foreach (obsCnt[i]) begin
      cmpCount++;
      if (obsCnt[i] !== expCnt[i]) begin
        errCount++; $display("[TB] FAIL rand_count[%0d]: got %0d expected %0d", i, obsCnt[i], expCnt[i]);
      end
    end
    clear_trace();
  endtask

  task automatic test_trap(input logic [5:0] badOp);
    clear_trace();
    run_instr(6'h08, 6'h00, 0, 0);
    run_instr(badOp, 6'h20, 0, 0);
    foreach (obsSt[i]) begin
      cmpCount++;
      if (obsSt[i] !== expSt[i] || obsCt[i] !== expCt[i]) begin
        errCount++; $display("[TB] FAIL trap_entry[%0d]: got st %0d ctrl %h expected st %0d ctrl %h",
                             i, obsSt[i], obsCt[i], expSt[i], expCt[i]);
      end
    end
    cmpCount++;
    if (obsSt.size() != 7 || obsSt[6] !== 15) begin
      errCount++; $display("[TB] FAIL trap_cycle: got %0d cycles expected 7 ending in 15", obsSt.size());
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      mem_ready = 1'($urandom_range(0, 1));
      opcode = 6'($urandom);
      #1;
      cmpCount++;
      if (state !== 4'd15 || dutCtrl() !== expCtrlFor(15, opcode, funct, mem_ready)) begin
        errCount++; $display("[TB] FAIL trap_hold: got st %0d ctrl %h expected st 15 ctrl %h",
                             state, dutCtrl(), expCtrlFor(15, opcode, funct, mem_ready));
      end
      cmpCount++;
      if (instr_count !== refCount) begin
        errCount++; $display("[TB] FAIL trap_count: got %0d expected %0d", instr_count, refCount);
      end
    end
    clear_trace();
    do_reset();
  endtask

  task automatic test_counter_wrap();
    @(negedge clk);
    force dut.r_instr_count = 32'hFFFF_FFFF;
    opcode = 6'h02;
    mem_ready = 1'b1;
    #1;
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    @(negedge clk);
    release dut.r_instr_count;
    #1;
    cmpCount++;
    if (state !== 4'd11 || instr_count !== 32'hFFFF_FFFF) begin
      errCount++; $display("[TB] FAIL wrap_pre: got st %0d count %h expected 11 ffffffff", state, instr_count);
    end
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    cmpCount++;
    if (state !== 4'd0 || instr_count !== 32'd0) begin
      errCount++; $display("[TB] FAIL wrap_post: got st %0d count %h expected 0 0", state, instr_count);
    end
    refCount = 32'd0;
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_wait_states();
    test_alu_decode();
    test_random();
    test_trap(6'h3F);
    test_trap(6'h23 ^ 6'h01);
    test_counter_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
    $finish;
  end

endmodule
